// File: rtl/adc_cal_pkg.sv
// ---------------------------------------------------------------------------
// adc_cal_pkg
// Shared definitions for the ADC foreground offset calibration block:
//   CODE_W      width of the raw ADC code and of the offset word
//   TARGET      ideal code for a shorted (mid-scale) input
//   cal_state_t calibration FSM states
//   clip_t      result of the signed clip (saturation flag + offset word)
//   clip_signed clip a CODE_W+1 bit signed difference into CODE_W bits
// ---------------------------------------------------------------------------
package adc_cal_pkg;

  localparam int CODE_W = 10;
  localparam int TARGET = 512;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    ACCUM   = 2'd2,
    COMPUTE = 2'd3
  } cal_state_t;

  typedef struct packed {
    logic              sat;
    logic [CODE_W-1:0] value;
  } clip_t;

  // Saturate into [-2^(CODE_W-1), 2^(CODE_W-1)-1]; sat flags that clipping occurred.
  function automatic clip_t clip_signed(input logic signed [CODE_W:0] diff);
    clip_t res;
    res = '0;
    if (diff > $signed({2'b00, {(CODE_W-1){1'b1}}})) begin
      res.sat   = 1'b1;
      res.value = {1'b0, {(CODE_W-1){1'b1}}};
    end else if (diff < $signed({2'b11, {(CODE_W-1){1'b0}}})) begin
      res.sat   = 1'b1;
      res.value = {1'b1, {(CODE_W-1){1'b0}}};
    end else begin
      res.value = diff[CODE_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/offset_cal_estimator_if.sv
// ---------------------------------------------------------------------------
// offset_cal_estimator_if
// Control/data bundle of the offset calibration block.
//   cal_start, cal_abort   calibration request / abandon (to estimator)
//   code_in, code_valid    raw SAR code and its qualifier (to estimator)
//   cal_mode, cal_busy     input-short switch control / activity status
//   offset, offset_vld     offset word for conditional_offset and its validity
//   cal_done, cal_sat      update pulse / last result was clipped
// master: the driving side (SAR/controller); slave: the estimator.
// ---------------------------------------------------------------------------
interface offset_cal_estimator_if;
  import adc_cal_pkg::*;

  logic              cal_start;
  logic              cal_abort;
  logic [CODE_W-1:0] code_in;
  logic              code_valid;
  logic              cal_mode;
  logic              cal_busy;
  logic [CODE_W-1:0] offset;
  logic              offset_vld;
  logic              cal_done;
  logic              cal_sat;

  modport master (
    output cal_start, cal_abort, code_in, code_valid,
    input  cal_mode, cal_busy, offset, offset_vld, cal_done, cal_sat
  );

  modport slave (
    input  cal_start, cal_abort, code_in, code_valid,
    output cal_mode, cal_busy, offset, offset_vld, cal_done, cal_sat
  );

endinterface

// File: rtl/cal_accumulator.sv
// ---------------------------------------------------------------------------
// cal_accumulator
// Sums 2^LOG2_N unsigned codes and counts them.
//   clk, rst_n   clock / synchronous active-low reset
//   clear        zero the sum and the sample count
//   add          accept code into the sum this cycle
//   code         raw unsigned ADC code
//   sum          running sum, wide enough that it never wraps
//   last_sample  high when the sample being added is the 2^LOG2_N-th
// ---------------------------------------------------------------------------
module cal_accumulator
  import adc_cal_pkg::*;
#(
  parameter int LOG2_N = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     add,
  input  logic [CODE_W-1:0]        code,
  output logic [CODE_W+LOG2_N-1:0] sum,
  output logic                     last_sample
);

  logic [LOG2_N-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sum   <= '0;
      count <= '0;
    end else if (add) begin
      sum   <= sum + {{LOG2_N{1'b0}}, code};
      count <= count + 1'b1;
    end
  end

  assign last_sample = add && (count == {LOG2_N{1'b1}});

endmodule

// File: rtl/offset_cal_estimator.sv
// ---------------------------------------------------------------------------
// offset_cal_estimator
// Foreground offset calibration: with the ADC input shorted to mid-scale,
// discards SETTLE_N valid codes, averages 2^LOG2_N codes and produces the
// signed offset word (corrected = raw + offset). The last good offset is held
// between calibrations.
//   clk, rst_n   clock / synchronous active-low reset
//   bus (slave)  cal_start, cal_abort, code_in, code_valid in;
//                cal_mode, cal_busy, offset, offset_vld, cal_done, cal_sat out
// ---------------------------------------------------------------------------
module offset_cal_estimator
  import adc_cal_pkg::*;
#(
  parameter int LOG2_N   = 4,
  parameter int SETTLE_N = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  offset_cal_estimator_if.slave  bus
);

  localparam int          SUM_W       = CODE_W + LOG2_N;
  localparam logic [15:0] SETTLE_LAST = 16'((SETTLE_N > 0) ? (SETTLE_N - 1) : 0);

  cal_state_t         state;
  cal_state_t         next_state;
  logic               start_accept;
  logic               acc_add;
  logic               do_update;
  logic               last_sample;
  logic [SUM_W-1:0]   sum;
  logic [15:0]        settle_cnt;
  logic               settle_done;
  logic [SUM_W:0]     rounded;
  logic [CODE_W-1:0]  mean;
  logic signed [CODE_W:0] diff;
  clip_t              clip_res;
  logic               unused_round_bits;

  cal_accumulator #(.LOG2_N(LOG2_N)) u_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (start_accept),
    .add         (acc_add),
    .code        (bus.code_in),
    .sum         (sum),
    .last_sample (last_sample)
  );

  // Round half up, then divide by 2^LOG2_N; the mean never exceeds the code range.
  assign rounded           = {1'b0, sum} + (SUM_W + 1)'(1 << (LOG2_N - 1));
  assign mean              = rounded[LOG2_N +: CODE_W];
  assign unused_round_bits = ^{rounded[LOG2_N-1:0], rounded[SUM_W]};
  assign diff              = $signed((CODE_W + 1)'(TARGET)) - $signed({1'b0, mean});
  assign clip_res          = clip_signed(diff);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Settle counter restarts with every accepted start and only counts valids.
  always_ff @(posedge clk) begin
    if (!rst_n || start_accept) begin
      settle_cnt <= '0;
    end else if (state == SETTLE && bus.code_valid) begin
      settle_cnt <= settle_cnt + 16'd1;
    end
  end

  assign settle_done = (settle_cnt == SETTLE_LAST);

  // Abort outranks both the final ACCUM sample and the COMPUTE update.
  always_comb begin
    next_state   = state;
    start_accept = 1'b0;
    acc_add      = 1'b0;
    do_update    = 1'b0;
    bus.cal_mode = 1'b0;
    bus.cal_busy = (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.cal_start) begin
          start_accept = 1'b1;
          next_state   = (SETTLE_N == 0) ? ACCUM : SETTLE;
        end
      end
      SETTLE: begin
        bus.cal_mode = 1'b1;
        if (bus.cal_abort) begin
          next_state = IDLE;
        end else if (bus.code_valid && settle_done) begin
          next_state = ACCUM;
        end
      end
      ACCUM: begin
        bus.cal_mode = 1'b1;
        acc_add      = bus.code_valid && !bus.cal_abort;
        if (bus.cal_abort) begin
          next_state = IDLE;
        end else if (last_sample) begin
          next_state = COMPUTE;
        end
      end
      COMPUTE: begin
        do_update  = !bus.cal_abort;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.offset     <= '0;
      bus.offset_vld <= 1'b0;
      bus.cal_sat    <= 1'b0;
      bus.cal_done   <= 1'b0;
    end else begin
      bus.cal_done <= do_update;
      if (do_update) begin
        bus.offset     <= clip_res.value;
        bus.cal_sat    <= clip_res.sat;
        bus.offset_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_offset_cal_estimator.sv
// ---------------------------------------------------------------------------
// tb_offset_cal_estimator
// Self-checking bench for offset_cal_estimator: each calibration run pushes
// its expected offset/saturation into a queue; a negedge monitor pops and
// compares on every cal_done and checks the pulse is one cycle wide.
// ---------------------------------------------------------------------------
module tb_offset_cal_estimator;
  import adc_cal_pkg::*;

  localparam int LOG2_N   = 4;
  localparam int SETTLE_N = 4;
  localparam int N        = 16;

  typedef struct packed {
    logic [CODE_W-1:0] off;
    logic              sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  offset_cal_estimator_if bus();

  offset_cal_estimator #(.LOG2_N(LOG2_N), .SETTLE_N(SETTLE_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks     = 0;
  int   failures   = 0;
  int   done_count = 0;
  logic prev_done  = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference rounding and clipping in plain integer arithmetic.
  function automatic exp_t model(input int sum);
    exp_t e;
    int   mean;
    int   diff;
    mean = (sum + N / 2) / N;
    diff = TARGET - mean;
    if (diff > 511) begin
      e.off = 10'd511;
      e.sat = 1'b1;
    end else if (diff < -512) begin
      e.off = 10'h200;
      e.sat = 1'b1;
    end else begin
      e.off = 10'(diff);
      e.sat = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.cal_done) begin
      checkOutput("done_width", {31'd0, prev_done}, 32'd0);
      checkOutput("busy_at_done", {31'd0, bus.cal_busy}, 32'd0);
      checkOutput("done_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("offset", {22'd0, bus.offset}, {22'd0, mon_e.off});
        checkOutput("cal_sat", {31'd0, bus.cal_sat}, {31'd0, mon_e.sat});
        checkOutput("offset_vld", {31'd0, bus.offset_vld}, 32'd1);
      end
      done_count++;
    end
    prev_done = bus.cal_done;
  end

  // Start pulse; the valid raised in the same cycle must be ignored.
  task automatic start_cal();
    bus.cal_start  = 1'b1;
    bus.code_valid = 1'b1;
    bus.code_in    = 10'd999;
    @(posedge clk); #1;
    bus.cal_start  = 1'b0;
    bus.code_valid = 1'b0;
  endtask

  task automatic feed(input logic [CODE_W-1:0] code, input int gap, input bit chk_mode);
    bus.code_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      if (chk_mode) checkOutput("cal_mode_gap", {31'd0, bus.cal_mode}, 32'd1);
      @(posedge clk); #1;
    end
    bus.code_in    = code;
    bus.code_valid = 1'b1;
    @(negedge clk);
    if (chk_mode) checkOutput("cal_mode_valid", {31'd0, bus.cal_mode}, 32'd1);
    @(posedge clk); #1;
    bus.code_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_count < target && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("done_timeout", {31'd0, done_count >= target}, 32'd1);
  endtask

  // One full calibration; alt toggles the LSB on odd samples.
  task automatic applyStimulus(input int base, input bit alt, input int max_gap,
                               input bit chk_mode, input bit poke, input bit chk_latency);
    logic [CODE_W-1:0] codes [SETTLE_N+N];
    int sum;
    int target;
    sum = 0;
    for (int i = 0; i < SETTLE_N + N; i++) begin
      codes[i] = 10'(base + (alt ? (i % 2) : 0));
      if (i >= SETTLE_N) sum += int'(codes[i]);
    end
    exp_q.push_back(model(sum));
    target = done_count + 1;
    start_cal();
    for (int i = 0; i < SETTLE_N + N; i++) begin
      feed(codes[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, chk_mode);
      if (poke && i == SETTLE_N + 3) begin
        bus.cal_start = 1'b1;
        @(posedge clk); #1;
        bus.cal_start = 1'b0;
      end
    end
    if (chk_latency) begin
      @(negedge clk);
      checkOutput("compute_done", {31'd0, bus.cal_done}, 32'd0);
      checkOutput("compute_mode", {31'd0, bus.cal_mode}, 32'd0);
      checkOutput("compute_busy", {31'd0, bus.cal_busy}, 32'd1);
    end
    wait_done(target);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    bus.cal_start  = 1'b1;
    bus.cal_abort  = 1'b0;
    bus.code_in    = '0;
    bus.code_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.cal_start = 1'b0;
    @(negedge clk);
    checkOutput("rst_offset", {22'd0, bus.offset}, 32'd0);
    checkOutput("rst_vld", {31'd0, bus.offset_vld}, 32'd0);
    checkOutput("rst_done", {31'd0, bus.cal_done}, 32'd0);
    checkOutput("rst_sat", {31'd0, bus.cal_sat}, 32'd0);
    checkOutput("rst_mode", {31'd0, bus.cal_mode}, 32'd0);
    checkOutput("rst_busy", {31'd0, bus.cal_busy}, 32'd0);
    @(posedge clk); #1;

    // Constant 522: offset -10, with exact latency checks.
    applyStimulus(522, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    checkOutput("case2_offset", {22'd0, bus.offset}, 32'h3F6);

    // Abort on the 8th ACCUM sample: nothing changes.
    start_cal();
    for (int i = 0; i < SETTLE_N + 7; i++) feed(10'd530, 0, 1'b0);
    bus.code_in    = 10'd530;
    bus.code_valid = 1'b1;
    bus.cal_abort  = 1'b1;
    @(posedge clk); #1;
    bus.code_valid = 1'b0;
    bus.cal_abort  = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", {31'd0, bus.cal_busy}, 32'd0);
    checkOutput("abort_done", {31'd0, bus.cal_done}, 32'd0);
    checkOutput("abort_offset", {22'd0, bus.offset}, 32'h3F6);
    checkOutput("abort_vld", {31'd0, bus.offset_vld}, 32'd1);
    repeat (4) @(posedge clk);
    #1;

    // Alternating 500/501, random gaps, stray start mid-ACCUM: offset +11.
    applyStimulus(500, 1'b1, 5, 1'b1, 1'b1, 1'b0);
    checkOutput("case3_offset", {22'd0, bus.offset}, 32'd11);

    // Extremes: code 0 saturates, code 1023 does not.
    applyStimulus(0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1023, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Reset during ACCUM, then a fresh mid-scale calibration.
    start_cal();
    for (int i = 0; i < SETTLE_N + 5; i++) feed(10'd600, 0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_accum_offset", {22'd0, bus.offset}, 32'd0);
    checkOutput("rst_accum_vld", {31'd0, bus.offset_vld}, 32'd0);
    checkOutput("rst_accum_busy", {31'd0, bus.cal_busy}, 32'd0);
    @(posedge clk); #1;
    applyStimulus(512, 1'b0, 1, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
